mem_copy_engine: RTL
====================

// Module: mem_copy_engine
// PURPOSE
//  Single-port memory initiator: on a start pulse, copies a block of LEN words from
//  SRC to DST in a single-port RAM. The RAM has a combinational read (valid when we=0),
//  a write on posedge when we=1, and a synchronous clear on rst.
//  Sits between the control logic and the RAM port, and owns that port while busy.
// PARAMETERS
//  DATA_WIDTH  8   word width; must match the RAM data width
//  ADDR_WIDTH  10  RAM address width; addresses wrap modulo 2**ADDR_WIDTH
// PORTS
//  clk         in   1           single clock; all state updates on posedge
//  rst         in   1           synchronous reset, active-high
//  start       in   1           request a copy; sampled only in IDLE
//  src_addr    in   ADDR_WIDTH  first source address; latched when start is accepted
//  dst_addr    in   ADDR_WIDTH  first destination address; latched when start is accepted
//  length      in   ADDR_WIDTH  number of words; 0 = empty copy; latched when start is accepted
//  busy        out  1           high in READ and WRITE states
//  done        out  1           one-cycle pulse in the DONE state
//  mem_addr    out  ADDR_WIDTH  RAM address
//  mem_we      out  1           RAM write enable (1 = write, 0 = read)
//  mem_wdata   out  DATA_WIDTH  RAM write data
//  mem_rdata   in   DATA_WIDTH  RAM read data; valid in the same cycle when mem_we=0
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0;
//    all pointers, counter and data_reg are cleared.
//  - Outputs are decoded from registered state only. There is no combinational
//    input->output path.
//  - States and transitions:
//    IDLE : mem_we=0, mem_addr=0.
//           If start=1: latch src/dst/len, clear cnt.
//           Go to READ if len!=0, else go to DONE.
//    READ : mem_addr=src_ptr, mem_we=0. At posedge: data_reg<=mem_rdata. Go to WRITE.
//    WRITE: mem_addr=dst_ptr, mem_we=1, mem_wdata=data_reg.
//           At posedge: src_ptr++, dst_ptr++, cnt++.
//           Go to DONE if cnt+1==len, else go to READ.
//    DONE : done=1, busy=0, mem_we=0. Next cycle go to IDLE.
//  - Throughput: 2 cycles per word.
//    Start accepted at edge 0 -> done is high during cycle 2*len+1.
//    len=0 -> done is high during cycle 1.
//  - Pointers wrap: 2**ADDR_WIDTH-1 + 1 -> 0.
//    cnt is ADDR_WIDTH+1 bits wide, so it never aliases.
//  - Overlap: the copy is strictly ascending. If dst lies in (src, src+len), later reads
//    return already-overwritten data. This is defined behaviour and is not an error.
//  - src==dst: every word is rewritten with its own value. Memory is unchanged.
//  - start while busy or in DONE: ignored, no queuing.
//  - Back-to-back jobs: start asserted in the cycle after DONE (back in IDLE) is accepted.
//  - Reset mid-operation: the engine returns to IDLE in the next cycle and no done pulse
//    is issued. rst also clears the RAM. Any partially copied data is lost.
//  - mem_wdata holds data_reg in every state; mem_we alone qualifies writes.
// TESTING
//  1. Preload RAM[0..3]=A1,B2,C3,D4; start src=0 dst=100 len=4
//     -> RAM[100..103]=A1,B2,C3,D4; done pulses once at cycle 9; busy high cycles 1-8.
//  2. start len=0
//     -> done at cycle 1; busy never rises; mem_we stays 0; RAM unchanged.
//  3. Wrap: RAM[1022]=11, RAM[1023]=22; src=1022 dst=1023 len=2
//     -> forward overlap gives RAM[1023]=11, RAM[0]=11; mem_addr sequence 1022,1023,1023,0.
//  4. Pulse start again at cycles 2 and 5 during a len=3 job
//     -> ignored; only one done pulse; source and destination unchanged by the extra starts.
//  5. Assert rst at cycle 4 of a len=8 job
//     -> next cycle: busy=0, mem_we=0, state IDLE, no done pulse; RAM all zero;
//        a new start then completes normally.
//  6. Two jobs back-to-back (second start in the cycle after done), src=dst=50 len=1
//     -> RAM[50] unchanged; exactly one mem_we pulse per job.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block copier that owns a single-port RAM while busy.
// Each word takes one read cycle and one write cycle.
//
// state | meaning
// IDLE  | waiting for start; RAM port parked at address 0, read mode
// READ  | drive src_ptr, capture RAM read data into data_q
// WRITE | drive dst_ptr with data_q, advance pointers and count
// DONE  | one-cycle completion pulse, then back to IDLE
module mem_copy_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  // One bit wider than the length so a full-memory copy never aliases to zero
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          len_d     = length;
          cnt_d     = '0;
          state_d   = (length != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        mem_addr = src_ptr_q;
        data_d   = mem_rdata;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_addr  = dst_ptr_q;
        mem_we    = 1'b1;
        src_ptr_d = src_ptr_q + 1'b1;
        dst_ptr_d = dst_ptr_q + 1'b1;
        cnt_d     = cnt_q + 1'b1;
        state_d   = (cnt_q + 1'b1 == {1'b0, len_q}) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
